// File: rtl/fifo_stream_ctrl.sv
// fifo_stream_ctrl: fill/drain sequencer for a 16-in/24-out FIFO.
// The fill side requests fixed bursts from a source when the buffer runs low.
// The drain side pops one sample per sample_tick, with a guard gap between pops.
// It keeps an authoritative bit-level occupancy count and reports underruns.
module fifo_stream_ctrl #(
    parameter int WR_W      = 16,
    parameter int RD_W      = 24,
    parameter int BUF_BITS  = 512,
    parameter int BURST_LEN = 8,
    parameter int LOW_BITS  = 128,
    parameter int POP_GUARD = 3
) (
    input  logic                      clk143,
    input  logic                      rst,
    input  logic                      en,
    output logic                      src_req,
    input  logic                      src_ack,
    input  logic                      src_valid,
    input  logic [WR_W-1:0]           src_data,
    output logic                      fifo_we,
    output logic [WR_W-1:0]           fifo_din,
    output logic                      fifo_pop,
    input  logic [RD_W-1:0]           fifo_dout,
    input  logic                      sample_tick,
    output logic [RD_W-1:0]           sample_out,
    output logic                      sample_valid,
    output logic                      underrun,
    output logic [15:0]               underrun_cnt,
    output logic [$clog2(BUF_BITS):0] level,
    output logic                      busy
);

    localparam int LVL_W = $clog2(BUF_BITS) + 1;
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam int GRD_W = $clog2(POP_GUARD + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BURST = 2'd2
    } fill_state_t;

    fill_state_t      state;
    fill_state_t      state_n;
    logic [CNT_W-1:0] word_cnt;
    logic [GRD_W-1:0] guard;
    logic             pending;

    logic wr_word;
    logic tick_req;
    logic svc;
    logic have_data;
    logic do_pop;
    logic do_under;

    // Saturating increment for the underrun counter.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Occupancy update in signed arithmetic: +WR_W per write, -RD_W per pop.
    function automatic logic [LVL_W-1:0] level_step(input logic [LVL_W-1:0] lvl,
                                                    input logic wr, input logic rd);
        logic signed [LVL_W+1:0] acc;
        acc = $signed({2'b00, lvl});
        if (wr) acc = acc + $signed((LVL_W+2)'(WR_W));
        if (rd) acc = acc - $signed((LVL_W+2)'(RD_W));
        return LVL_W'(acc);
    endfunction

    assign wr_word   = (state == BURST) && src_valid;
    assign tick_req  = en && sample_tick;
    assign svc       = en && (guard == '0) && (pending || sample_tick);
    assign have_data = (level >= LVL_W'(RD_W));
    assign do_pop    = svc && have_data;
    assign do_under  = svc && !have_data;
    assign busy      = (state != IDLE);

    // Fill FSM next-state logic; an ack takes priority over en falling in REQ.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (en && (level <= LVL_W'(LOW_BITS))) state_n = REQ;
            REQ:     if (src_ack) state_n = BURST;
                     else if (!en) state_n = IDLE;
            BURST:   if (src_valid && (word_cnt == CNT_W'(BURST_LEN - 1))) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Fill FSM state register, registered request and burst word counter.
    always_ff @(posedge clk143 or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            src_req  <= 1'b0;
            word_cnt <= '0;
        end else begin
            state   <= state_n;
            src_req <= (state_n == REQ);
            if (state == REQ && src_ack) word_cnt <= '0;
            else if (wr_word)            word_cnt <= word_cnt + CNT_W'(1);
        end
    end

    // Write path: each accepted source word is registered into the FIFO port.
    always_ff @(posedge clk143 or posedge rst) begin
        if (rst) begin
            fifo_we  <= 1'b0;
            fifo_din <= '0;
        end else begin
            fifo_we <= wr_word;
            if (wr_word) fifo_din <= src_data;
        end
    end

    // Occupancy moves on the same edge that raises fifo_we / fifo_pop.
    always_ff @(posedge clk143 or posedge rst) begin
        if (rst) level <= '0;
        else     level <= level_step(level, wr_word, do_pop);
    end

    // Drain path: guard spacing makes consecutive pops land POP_GUARD cycles apart,
    // giving the FIFO's registered dout time to settle on the new head.
    always_ff @(posedge clk143 or posedge rst) begin
        if (rst) begin
            guard        <= '0;
            pending      <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            fifo_pop     <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            fifo_pop     <= 1'b0;
            if (do_pop)              guard <= GRD_W'(POP_GUARD - 1);
            else if (guard != '0)    guard <= guard - GRD_W'(1);
            if (!en) begin
                pending <= 1'b0;
                if (sample_tick) begin
                    sample_valid <= 1'b1;
                    sample_out   <= '0;
                end
            end else if (svc) begin
                pending      <= 1'b0;
                sample_valid <= 1'b1;
                fifo_pop     <= do_pop;
                sample_out   <= do_pop ? fifo_dout : '0;
            end else if (tick_req) begin
                pending <= 1'b1;
            end
        end
    end

    // Underrun reporting; both flag and count clear while the stream is disabled.
    always_ff @(posedge clk143 or posedge rst) begin
        if (rst) begin
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else if (!en) begin
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else if (do_under) begin
            underrun     <= 1'b1;
            underrun_cnt <= sat_inc(underrun_cnt);
        end
    end

    level_bound_a: assert property (@(posedge clk143) disable iff (rst)
                                    level <= LVL_W'(BUF_BITS));

endmodule

// File: tb/tb_fifo_stream_ctrl.sv
// Bench for fifo_stream_ctrl: directed sequences, a drain vector table,
// and a randomized run against a transaction-level reference model.
module tb_fifo_stream_ctrl;

    localparam int WR_W      = 16;
    localparam int RD_W      = 24;
    localparam int BUF_BITS  = 512;
    localparam int BURST_LEN = 8;
    localparam int LOW_BITS  = 128;
    localparam int POP_GUARD = 3;

    logic        clk143 = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        src_req;
    logic        src_ack = 1'b0;
    logic        src_valid = 1'b0;
    logic [15:0] src_data = '0;
    logic        fifo_we;
    logic [15:0] fifo_din;
    logic        fifo_pop;
    logic [23:0] fifo_dout = '0;
    logic        sample_tick = 1'b0;
    logic [23:0] sample_out;
    logic        sample_valid;
    logic        underrun;
    logic [15:0] underrun_cnt;
    logic [9:0]  level;
    logic        busy;

    int checks = 0;
    int failures = 0;
    logic [15:0] last_word;

    fifo_stream_ctrl #(
        .WR_W(WR_W), .RD_W(RD_W), .BUF_BITS(BUF_BITS),
        .BURST_LEN(BURST_LEN), .LOW_BITS(LOW_BITS), .POP_GUARD(POP_GUARD)
    ) dut (
        .clk143(clk143), .rst(rst), .en(en),
        .src_req(src_req), .src_ack(src_ack), .src_valid(src_valid), .src_data(src_data),
        .fifo_we(fifo_we), .fifo_din(fifo_din), .fifo_pop(fifo_pop), .fifo_dout(fifo_dout),
        .sample_tick(sample_tick), .sample_out(sample_out), .sample_valid(sample_valid),
        .underrun(underrun), .underrun_cnt(underrun_cnt), .level(level), .busy(busy)
    );

    always #5 clk143 = ~clk143;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; src_ack = 1'b0; src_valid = 1'b0;
        sample_tick = 1'b0; fifo_dout = '0;
        repeat (2) @(negedge clk143);
        rst = 1'b0;
    endtask

    task automatic send_words(input int n);
        for (int i = 0; i < n; i++) begin
            src_valid = 1'b1;
            src_data  = 16'(16'hA000 + 16'(i * 37));
            last_word = src_data;
            @(negedge clk143);
        end
        src_valid = 1'b0;
    endtask

    task automatic ack_burst(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (src_req) ok = 1'b1;
            else @(negedge clk143);
        end
        chk("req_seen", 72'(ok), 72'(1));
        if (ok) begin
            src_ack = 1'b1;
            @(negedge clk143);
            src_ack = 1'b0;
            send_words(n);
        end
    endtask

    // ---------------- reference model (used in the random phase) ----------
    int          m_level, m_owed, m_cnt, m_cyc, m_next_ok;
    bit          m_req, m_pend, m_under, m_we, m_pop, m_sv;
    logic [15:0] m_din;
    logic [23:0] m_so;

    always @(posedge clk143) begin
        if (rst) begin
            m_level = 0; m_owed = 0; m_cnt = 0; m_cyc = 0; m_next_ok = 0;
            m_req = 0; m_pend = 0; m_under = 0; m_we = 0; m_pop = 0; m_sv = 0;
            m_din = '0; m_so = '0;
        end else begin
            int lvl0;
            bit wr, pop;
            lvl0 = m_level;
            wr   = (m_owed > 0) && src_valid;
            pop  = 1'b0;
            // fill: words owed to the current burst, else request handshake
            if (m_owed > 0) begin
                if (src_valid) m_owed = m_owed - 1;
            end else if (m_req) begin
                if (src_ack) begin m_req = 0; m_owed = BURST_LEN; end
                else if (!en) m_req = 0;
            end else if (en && lvl0 <= LOW_BITS) begin
                m_req = 1;
            end
            m_we = wr;
            if (wr) m_din = src_data;
            // drain: service allowed from cycle m_next_ok onward
            m_sv = 0;
            if (!en) begin
                m_pend = 0; m_under = 0; m_cnt = 0;
                if (sample_tick) begin m_sv = 1; m_so = '0; end
            end else if ((sample_tick || m_pend) && m_cyc >= m_next_ok) begin
                m_pend = 0; m_sv = 1;
                if (lvl0 >= RD_W) begin
                    pop = 1; m_so = fifo_dout; m_next_ok = m_cyc + POP_GUARD;
                end else begin
                    m_so = '0; m_under = 1;
                    if (m_cnt < 65535) m_cnt = m_cnt + 1;
                end
            end else if (sample_tick) begin
                m_pend = 1;
            end
            m_pop   = pop;
            m_level = lvl0 + (wr ? WR_W : 0) - (pop ? RD_W : 0);
            m_cyc   = m_cyc + 1;
        end
    end

    typedef struct {
        logic        en;
        logic        tick;
        logic [23:0] dout;
        logic        e_pop;
        logic        e_valid;
        logic [23:0] e_out;
        logic [9:0]  e_level;
    } row_t;

    row_t vec [10];

    initial begin
        int src_left;

        vec[0] = '{1'b1, 1'b1, 24'h111111, 1'b1, 1'b1, 24'h111111, 10'd232};
        vec[1] = '{1'b1, 1'b1, 24'h222222, 1'b0, 1'b0, 24'h111111, 10'd232};
        vec[2] = '{1'b1, 1'b1, 24'h333333, 1'b0, 1'b0, 24'h111111, 10'd232};
        vec[3] = '{1'b1, 1'b0, 24'h444444, 1'b1, 1'b1, 24'h444444, 10'd208};
        vec[4] = '{1'b1, 1'b0, 24'h555555, 1'b0, 1'b0, 24'h444444, 10'd208};
        vec[5] = '{1'b1, 1'b0, 24'h666666, 1'b0, 1'b0, 24'h444444, 10'd208};
        vec[6] = '{1'b1, 1'b0, 24'h666666, 1'b0, 1'b0, 24'h444444, 10'd208};
        vec[7] = '{1'b0, 1'b1, 24'h777777, 1'b0, 1'b1, 24'h000000, 10'd208};
        vec[8] = '{1'b1, 1'b0, 24'h777777, 1'b0, 1'b0, 24'h000000, 10'd208};
        vec[9] = '{1'b1, 1'b1, 24'h888888, 1'b1, 1'b1, 24'h888888, 10'd184};

        // Reset state, then two bursts fill to 256
        do_reset();
        @(negedge clk143);
        chk("reset_state", 72'({src_req, busy, fifo_we, fifo_din, fifo_pop, sample_valid,
                                sample_out, underrun, underrun_cnt, level}), 72'(0));
        en = 1'b1;
        ack_burst(BURST_LEN);
        chk("burst1", 72'({fifo_we, fifo_din, level}), 72'({1'b1, last_word, 10'd128}));
        ack_burst(BURST_LEN);
        chk("burst2_level", 72'(level), 72'(256));
        @(negedge clk143);
        chk("idle_after_fill", 72'({busy, src_req, level}), 72'({1'b0, 1'b0, 10'd256}));

        // Drain vector table: pop spacing, pending tick, dropped tick, en=0 tick
        for (int i = 0; i < 10; i++) begin
            en = vec[i].en; sample_tick = vec[i].tick; fifo_dout = vec[i].dout;
            @(negedge clk143);
            chk($sformatf("drain_row%0d", i),
                72'({fifo_pop, sample_valid, sample_out, level, underrun_cnt}),
                72'({vec[i].e_pop, vec[i].e_valid, vec[i].e_out, vec[i].e_level, 16'd0}));
        end
        sample_tick = 1'b0; en = 1'b1;

        // Underrun with a source that never acks, then en=0 clears it
        do_reset();
        en = 1'b1;
        @(negedge clk143);
        sample_tick = 1'b1; @(negedge clk143); sample_tick = 1'b0;
        chk("underrun1", 72'({sample_valid, sample_out, fifo_pop, underrun, underrun_cnt}),
            72'({1'b1, 24'd0, 1'b0, 1'b1, 16'd1}));
        sample_tick = 1'b1; @(negedge clk143); sample_tick = 1'b0;
        chk("underrun2", 72'({sample_valid, fifo_pop, underrun, underrun_cnt}),
            72'({1'b1, 1'b0, 1'b1, 16'd2}));
        en = 1'b0; @(negedge clk143);
        chk("en_low_clear", 72'({underrun, underrun_cnt, src_req, busy}), 72'(0));

        // Simultaneous write and pop at level 200
        do_reset();
        en = 1'b1;
        ack_burst(BURST_LEN);
        sample_tick = 1'b1; @(negedge clk143); sample_tick = 1'b0;
        chk("pop_at_128", 72'({fifo_pop, level}), 72'({1'b1, 10'd104}));
        ack_burst(6);
        chk("level_200", 72'(level), 72'(200));
        src_valid = 1'b1; src_data = 16'hBEEF; sample_tick = 1'b1;
        @(negedge clk143);
        src_valid = 1'b0; sample_tick = 1'b0;
        chk("we_and_pop", 72'({fifo_we, fifo_din, fifo_pop, level}),
            72'({1'b1, 16'hBEEF, 1'b1, 10'd192}));
        send_words(1);
        chk("burst_done", 72'({busy, level}), 72'({1'b0, 10'd208}));

        // Asynchronous reset in the middle of a burst
        do_reset();
        en = 1'b1;
        ack_burst(3);
        chk("mid_burst", 72'({fifo_we, busy, level}), 72'({1'b1, 1'b1, 10'd48}));
        #2 rst = 1'b1;
        #1;
        chk("async_rst", 72'({src_req, fifo_we, busy, level}), 72'(0));
        @(negedge clk143); rst = 1'b0;
        @(negedge clk143);
        chk("req_after_rst", 72'({src_req, busy}), 72'({1'b1, 1'b1}));

        // Randomized run against the reference model
        do_reset();
        en = 1'b1; src_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) en = !en;
            src_ack = 1'b0;
            if (src_left > 0) begin
                src_valid = ($urandom_range(0, 2) != 0);
                src_data  = 16'($urandom);
                if (src_valid) src_left--;
            end else if (src_req && $urandom_range(0, 2) == 0) begin
                src_ack = 1'b1; src_valid = 1'b0; src_left = BURST_LEN;
            end else begin
                src_valid = ($urandom_range(0, 7) == 0);
                src_data  = 16'($urandom);
            end
            sample_tick = ($urandom_range(0, 3) == 0);
            fifo_dout   = 24'($urandom);
            @(negedge clk143);
            chk($sformatf("random_cyc%0d", c),
                72'({src_req, busy, fifo_we, fifo_din, fifo_pop, sample_valid, sample_out,
                     underrun, underrun_cnt, level}),
                72'({m_req, (m_req || m_owed > 0), m_we, m_din, m_pop, m_sv, m_so,
                     m_under, 16'(m_cnt), 10'(m_level)}));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_stream_ctrl.md
Name: fifo_stream_ctrl

Overview:
- Sequences the 16-in/24-out fifo_buffer that sits between a 16-bit burst source (memory reader) and a 24-bit sample sink (audio output path).
- Fill side: requests fixed-length bursts from the source when the buffer runs low and writes the returned words into the FIFO.
- Drain side: pops one 24-bit sample per sample_tick and presents it to the sink.
- Keeps its own occupancy count in bits, which is the authoritative level, and reports underruns.

Parameters:
- WR_W, 16, FIFO write word width in bits.
- RD_W, 24, FIFO read word width in bits.
- BUF_BITS, 512, FIFO capacity in bits.
- BURST_LEN, 8, number of WR_W words per source burst.
- LOW_BITS, 128, refill threshold; a refill is requested when level <= LOW_BITS. Constraint: LOW_BITS + BURST_LEN*WR_W <= BUF_BITS.
- POP_GUARD, 3, minimum cycles between FIFO pops, which allows for the registered dout of fifo_buffer.

Ports:
- clk143  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  stream enable.
- src_req  out  1  burst request to the source.
- src_ack  in  1  one-cycle acceptance of the request.
- src_valid  in  1  source data word valid.
- src_data  in  WR_W  source data word.
- fifo_we  out  1  FIFO write enable.
- fifo_din  out  WR_W  FIFO write data.
- fifo_pop  out  1  FIFO pop_front, one-cycle pulse.
- fifo_dout  in  RD_W  FIFO head word.
- sample_tick  in  1  sample-rate strobe, one cycle wide.
- sample_out  out  RD_W  sample presented to the sink.
- sample_valid  out  1  one-cycle qualifier for sample_out.
- underrun  out  1  sticky underrun flag.
- underrun_cnt  out  16  saturating underrun count.
- level  out  $clog2(BUF_BITS)+1  current occupancy in bits.
- busy  out  1  high whenever the fill FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock, clk143. Reset is asynchronous and active-high.
- Reset values: all outputs are 0, the fill FSM is in IDLE, the guard counter is 0 and the pending flag is 0.
- Reset mid-burst: the burst is abandoned and src_req drops immediately. rst must be applied together with FIFO re-initialisation.

Fill FSM states: IDLE, REQ, BURST.
- IDLE -> REQ when en && level <= LOW_BITS.
- REQ: src_req=1 (registered) is held until src_ack, then -> BURST with word_cnt=0. If en falls while in REQ without src_ack: drop src_req, -> IDLE.
- BURST: each src_valid cycle registers fifo_we=1 and fifo_din=src_data on the next cycle, and word_cnt increments.
- After BURST_LEN words: -> IDLE. Re-evaluation of the IDLE condition is allowed on the following cycle.
- A burst is always completed once acked, even if en falls. The source is never stalled.
- src_valid outside BURST is ignored.

Drain:
- A sample_tick with en=1 is serviced when guard==0; otherwise it sets pending. pending is serviced on the first cycle with guard==0.
- Extra ticks while pending is already set are dropped.
- Service at cycle T:
  - If level >= RD_W: at T+1, sample_out=fifo_dout sampled at T, sample_valid=1, fifo_pop=1, guard=POP_GUARD.
  - Else (underrun): at T+1, sample_out=0, sample_valid=1, no pop, underrun=1, underrun_cnt increments (saturates at 16'hFFFF).
- en=0: a tick yields sample_out=0 and sample_valid=1 at T+1, with no pop and no count. underrun and underrun_cnt clear while en=0.

Level arithmetic:
- level updates in the same cycle as fifo_we and fifo_pop.
- +WR_W on write, -RD_W on pop, net WR_W-RD_W (-8) when both occur.
- level never exceeds BUF_BITS by construction. An assertion covers this in simulation.

Test Plan:
- rst, then en=1, level 0: src_req=1; ack, then 8 src_valid words -> level=128, second request -> level=256, FSM IDLE, busy=0.
- level=256, tick at T: sample_out=fifo_dout at T+1, fifo_pop pulses 1 cycle, level=232.
- Ticks at T and T+1: pops at T+1 and T+4. A third tick at T+2 is dropped.
- en=1, source never acks, tick: sample_out=0, sample_valid=1, underrun=1, underrun_cnt=1, fifo_pop stays 0.
- fifo_we and fifo_pop in the same cycle at level=200 -> level=192.
- rst asserted mid-BURST after 3 words: src_req, fifo_we and level go to 0 asynchronously, FSM IDLE. After release with en=1, a fresh request is issued.
